alu_seq_param: RTL and testbench
================================

Name: alu_seq_param

Overview:
- Parametrised multi-cycle integer ALU; next generation of the 16-bit add/sub/mul/div ALU in the datapath.
- Width is generic (WIDTH).
- Multiply and divide are iterative in-block (no vendor IP), so there is no fixed-latency assumption and no IP warm-up cycles.
- Uses a valid/ready handshake on input and output, adds remainder and logic ops, and reports divide-by-zero, overflow and illegal-op status.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
Sysclk  in  1  ALU clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
Op  in  3  operation select, sampled on input accept
SrcA  in  WIDTH  operand A / dividend / multiplicand
SrcB  in  WIDTH  operand B / divisor / multiplier
In_Valid  in  1  operands and Op valid
In_Ready  out  1  ALU can accept; high only in IDLE
Result  out  WIDTH  primary result (sum, difference, product low word, quotient, remainder, logic)
Result_Hi  out  WIDTH  product high word for MUL; 0 for all other ops
Out_Valid  out  1  Result and flags valid
Out_Ready  in  1  consumer takes result
Overflow  out  1  carry (ADD), borrow (SUB), Result_Hi!=0 (MUL), else 0
Div_Zero  out  1  DIV/REM with SrcB==0
Op_Err  out  1  reserved Op code accepted

Behaviour:
- Op encoding (unsigned arithmetic throughout): 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 REM, 101 AND, 110 OR, 111 reserved.
- Reset (async assert, sync release):
  - State is IDLE; Result, Result_Hi, Out_Valid, Overflow, Div_Zero, Op_Err are 0; counter and operand registers are 0.
  - In_Ready = (state==IDLE), so it is 1 during and after reset.
- Input accept: In_Valid && In_Ready at a rising edge. Op, SrcA and SrcB are captured; later input changes are ignored until the next accept.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ADD/SUB/AND/OR/reserved -> DONE, with the result registered on the accept edge. Out_Valid is high the cycle after accept (latency 1).
  - DIV/REM with SrcB==0 -> DONE, latency 1, Div_Zero=1.
  - MUL, and DIV/REM with SrcB!=0 -> CALC, with counter loaded to WIDTH-1.
- CALC:
  - One shift-add (MUL) or one restoring subtract-shift (DIV/REM) step per cycle.
  - At counter==0, go to DONE. Out_Valid asserts exactly WIDTH+1 cycles after the accept edge.
- DONE:
  - Out_Valid=1; Result, Result_Hi and flags are held stable.
  - On Out_Ready go to IDLE; Out_Valid drops the next cycle.
  - No new accept in the same cycle as the output handshake (In_Ready is 0 in DONE).
- Arithmetic:
  - ADD: Result = (A+B) mod 2^WIDTH; Overflow = carry out.
  - SUB: Result = (A-B) mod 2^WIDTH; Overflow = A<B.
  - MUL: full 2*WIDTH product, {Result_Hi, Result}.
  - DIV: Result = floor(A/B).
  - REM: Result = A mod B.
- Divide by zero: quotient = all ones, REM result = SrcA, Overflow=0.
- Reserved op: Result=0, Op_Err=1, other flags 0.
- Flags are cleared at each accept and are meaningful only while Out_Valid=1.
- Out_Ready while not in DONE: ignored.
- Reset in CALC or DONE aborts the operation; no Out_Valid is issued for it.

Decomposition:
- Package alu_seq_pkg holds the Op encoding constants (OP_ADD..OP_RSVD) and the state enum (ST_IDLE, ST_CALC, ST_DONE).
- Sub-module alu_iter_div: restoring divider with start/busy/done, WIDTH-parametrised, outputs quotient and remainder.
- The multiplier stays inline in alu_seq_param.

Test Plan (WIDTH=16):
- ADD 0xFFFF+0x0001 -> Result 0x0000, Overflow=1, Out_Valid 1 cycle after accept, Result_Hi=0.
- SUB 5-7 -> Result 0xFFFE, Overflow=1; then AND 0xF0F0,0x3C3C -> 0x3030, Overflow=0.
- MUL 0x1234*0x0100 -> Result 0x3400, Result_Hi 0x0012, Overflow=1, Out_Valid exactly 17 cycles after accept.
- DIV 100/7 -> 0x000E; REM 100/7 -> 0x0002 (latency 17); DIV 50/0 -> 0xFFFF, Div_Zero=1, latency 1.
- Hold Out_Ready=0 for 5 cycles in DONE while driving In_Valid with new operands -> outputs stable, In_Ready=0, no accept; release Out_Ready -> IDLE, next op is the new one.
- Assert Reset 8 cycles into a DIV -> all outputs 0, In_Ready=1 immediately; after release, ADD 3+4 -> 0x0007 with no stale Out_Valid.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU: operation encoding and control states.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_REM  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_div.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start edge so results are registered one cycle early.
module alu_iter_div #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Sysclk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;

  // quo carries the unconsumed dividend bits out of its top and quotient bits in at its bottom
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    if (diff[WIDTH]) begin
      div_step = {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    end
  endfunction

  // Iteration registers: load plus first step on start, then one step per busy cycle
  always_ff @(posedge Sysclk or posedge Reset) begin
    if (Reset) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      {rem_r, quo_r} <= div_step({WIDTH{1'b0}}, dividend, divisor);
      dvs_r  <= divisor;
      cnt_r  <= CNT_W'(WIDTH - 1);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      {rem_r, quo_r} <= div_step(rem_r, quo_r, dvs_r);
      cnt_r  <= cnt_r - CNT_W'(1);
      if (cnt_r == CNT_W'(1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/alu_seq_param.sv
// Multi-cycle unsigned ALU with valid/ready handshakes; single-cycle ops finish on
// the accept edge, MUL (inline shift-add) and DIV/REM (alu_iter_div) iterate WIDTH times.
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Sysclk,
  input  logic             Reset,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_Hi,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Overflow,
  output logic             Div_Zero,
  output logic             Op_Err
);

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   result_hi_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               overflow_r;
  logic               div_zero_r;
  logic               op_err_r;
  logic               accept_s;
  logic               div_op_s;
  logic               needs_calc_s;
  logic               div_start_s;
  logic               calc_last_s;
  logic               div_busy_s;
  logic               div_done_s;
  logic [WIDTH-1:0]   div_quot_s;
  logic [WIDTH-1:0]   div_rem_s;

  assign accept_s     = In_Valid && in_ready_r;
  assign div_op_s     = (Op == OP_DIV) || (Op == OP_REM);
  assign needs_calc_s = (Op == OP_MUL) || (div_op_s && (SrcB != {WIDTH{1'b0}}));
  assign div_start_s  = accept_s && div_op_s && (SrcB != {WIDTH{1'b0}});

  // prod_r holds {partial sum, remaining multiplier bits}; the add carry lands in the top bit
  assign mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};

  assign calc_last_s = (cnt_r == {CNT_W{1'b0}}) &&
                       ((op_r == OP_MUL) || (div_done_s && !div_busy_s));

  alu_iter_div #(.WIDTH(WIDTH)) u_div (
    .Sysclk    (Sysclk),
    .Reset     (Reset),
    .start     (div_start_s),
    .dividend  (SrcA),
    .divisor   (SrcB),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quot_s),
    .remainder (div_rem_s)
  );

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = needs_calc_s ? ST_CALC : ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (calc_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (Out_Ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, operand capture, iteration and result/flag registers
  always_ff @(posedge Sysclk or posedge Reset) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      cnt_r       <= '0;
      op_r        <= 3'b000;
      a_r         <= '0;
      prod_r      <= '0;
      result_r    <= '0;
      result_hi_r <= '0;
      overflow_r  <= 1'b0;
      div_zero_r  <= 1'b0;
      op_err_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r        <= Op;
            a_r         <= SrcA;
            prod_r      <= {{WIDTH{1'b0}}, SrcB};
            cnt_r       <= CNT_W'(WIDTH - 1);
            result_r    <= '0;
            result_hi_r <= '0;
            overflow_r  <= 1'b0;
            div_zero_r  <= 1'b0;
            op_err_r    <= 1'b0;
            case (Op)
              OP_ADD: {overflow_r, result_r} <= {1'b0, SrcA} + {1'b0, SrcB};
              OP_SUB: begin
                result_r   <= SrcA - SrcB;
                overflow_r <= (SrcA < SrcB);
              end
              OP_AND: result_r <= SrcA & SrcB;
              OP_OR:  result_r <= SrcA | SrcB;
              OP_DIV: begin
                if (SrcB == {WIDTH{1'b0}}) begin
                  result_r   <= {WIDTH{1'b1}};
                  div_zero_r <= 1'b1;
                end
              end
              OP_REM: begin
                if (SrcB == {WIDTH{1'b0}}) begin
                  result_r   <= SrcA;
                  div_zero_r <= 1'b1;
                end
              end
              OP_RSVD: op_err_r <= 1'b1;
              default: result_r <= '0;
            endcase
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (op_r == OP_MUL) begin
            prod_r <= mul_next_s;
          end
          if (calc_last_s) begin
            case (op_r)
              OP_MUL: begin
                result_r    <= mul_next_s[WIDTH-1:0];
                result_hi_r <= mul_next_s[2*WIDTH-1:WIDTH];
                overflow_r  <= |mul_next_s[2*WIDTH-1:WIDTH];
              end
              OP_DIV:  result_r <= div_quot_s;
              OP_REM:  result_r <= div_rem_s;
              default: result_r <= '0;
            endcase
          end
        end
        ST_DONE: begin
          result_r <= result_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign In_Ready  = in_ready_r;
  assign Out_Valid = out_valid_r;
  assign Result    = result_r;
  assign Result_Hi = result_hi_r;
  assign Overflow  = overflow_r;
  assign Div_Zero  = div_zero_r;
  assign Op_Err    = op_err_r;

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param (WIDTH=16): driver queues hand-computed
// expectations, a negedge monitor checks latency, hold stability and results.
module tb_alu_seq_param;

  localparam int W = 16;

  logic         Sysclk = 1'b0;
  logic         Reset;
  logic [2:0]   Op;
  logic [W-1:0] SrcA, SrcB;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] Result, Result_Hi;
  logic         Out_Valid;
  logic         Out_Ready;
  logic         Overflow, Div_Zero, Op_Err;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ovf;
    logic         dz;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  logic ov_prev = 1'b0;

  alu_seq_param #(.WIDTH(W)) dut (
    .Sysclk    (Sysclk),
    .Reset     (Reset),
    .Op        (Op),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Result    (Result),
    .Result_Hi (Result_Hi),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Overflow  (Overflow),
    .Div_Zero  (Div_Zero),
    .Op_Err    (Op_Err)
  );

  always #5 Sysclk = ~Sysclk;

  always @(posedge Sysclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor: latency on Out_Valid rise, stability while held, full compare on handshake
  always @(negedge Sysclk) begin
    if (Reset) begin
      ov_prev = 1'b0;
    end else begin
      if (In_Valid && In_Ready) acc_cyc = cyc + 1;
      if (Out_Valid && sb.size() == 0) begin
        timeout("unexpected_out_valid");
      end else if (Out_Valid) begin
        if (!ov_prev) chk("latency", cyc - acc_cyc + 1, sb[0].lat);
        chk("in_ready_in_done", {31'd0, In_Ready}, 32'd0);
        if (!Out_Ready) begin
          chk("hold_result", {16'd0, Result}, {16'd0, sb[0].res});
          chk("hold_hi", {16'd0, Result_Hi}, {16'd0, sb[0].hi});
        end else begin
          chk("result", {16'd0, Result}, {16'd0, sb[0].res});
          chk("result_hi", {16'd0, Result_Hi}, {16'd0, sb[0].hi});
          chk("overflow", {31'd0, Overflow}, {31'd0, sb[0].ovf});
          chk("div_zero", {31'd0, Div_Zero}, {31'd0, sb[0].dz});
          chk("op_err", {31'd0, Op_Err}, {31'd0, sb[0].err});
          void'(sb.pop_front());
        end
      end
      ov_prev = Out_Valid;
    end
  end

  task automatic push(input logic [W-1:0] res, input logic [W-1:0] hi,
                      input logic ovf, input logic dz, input logic err, input int lat);
    exp_t e;
    e.res = res; e.hi = hi; e.ovf = ovf; e.dz = dz; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  // Drive In_Valid until accepted; entered and left at posedge+1
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    Op = op; SrcA = a; SrcB = b; In_Valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Sysclk);
      if (In_Ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("accept");
    @(posedge Sysclk); #1;
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Sysclk); #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("drain");
  endtask

  task automatic op_chk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic [W-1:0] hi,
                        input logic ovf, input logic dz, input logic err, input int lat);
    push(res, hi, ovf, dz, err, lat);
    issue(op, a, b);
    drain();
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_result"}, {16'd0, Result}, 32'd0);
    chk({tag, "_result_hi"}, {16'd0, Result_Hi}, 32'd0);
    chk({tag, "_flags"}, {28'd0, Out_Valid, Overflow, Div_Zero, Op_Err}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, In_Ready}, 32'd1);
  endtask

  initial begin
    Reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1;
    Op = 3'b000; SrcA = 16'h0000; SrcB = 16'h0000;
    repeat (2) @(posedge Sysclk);
    #1;
    idle_chk("reset");
    Reset = 1'b0;
    @(posedge Sysclk); #1;

    //      op      A         B         Result    Hi        ovf   dz    err   lat
    op_chk(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
    op_chk(3'b001, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
    op_chk(3'b101, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
    op_chk(3'b110, 16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
    op_chk(3'b010, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b0, 1'b0, 17);
    op_chk(3'b010, 16'h00FF, 16'h00FF, 16'hFE01, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
    op_chk(3'b010, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 17);
    op_chk(3'b011, 16'd100,  16'd7,    16'h000E, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
    op_chk(3'b100, 16'd100,  16'd7,    16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
    op_chk(3'b011, 16'd50,   16'd0,    16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
    op_chk(3'b100, 16'd50,   16'd0,    16'h0032, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
    op_chk(3'b011, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
    op_chk(3'b100, 16'hFFFF, 16'h0010, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
    op_chk(3'b011, 16'h0007, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
    op_chk(3'b111, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    op_chk(3'b000, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1);

    // Back-pressure in DONE while a new operation is presented
    Out_Ready = 1'b0;
    push(16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
    issue(3'b000, 16'h0001, 16'h0002);
    Op = 3'b110; SrcA = 16'h00F0; SrcB = 16'h0F00; In_Valid = 1'b1;
    repeat (5) @(posedge Sysclk);
    #1;
    push(16'h0FF0, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
    Out_Ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge Sysclk);
        if (In_Ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) timeout("accept_after_hold");
      @(posedge Sysclk); #1;
      In_Valid = 1'b0;
    end
    drain();

    // Reset in the middle of a divide
    push(16'd333, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
    issue(3'b011, 16'd1000, 16'd3);
    repeat (7) @(posedge Sysclk);
    #1;
    Reset = 1'b1;
    sb.delete();
    #1;
    idle_chk("abort");
    repeat (2) @(posedge Sysclk);
    #1;
    Reset = 1'b0;
    idle_chk("post_abort");
    repeat (20) @(posedge Sysclk);
    #1;
    op_chk(3'b000, 16'd3, 16'd4, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 1);

    repeat (3) @(posedge Sysclk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
